pwm_ramp_ctrl: RTL

//  Configuration sequencer between the Nios II PIO registers and the PWM

---
 rtl/pwm_ramp_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pwm_ramp_ctrl.sv
// PWM config sequencer: validates period/duty loads and applies them at pwm_wrap, optionally ramping duty.
// Latency: act_* update the edge of pwm_wrap. No backpressure; a load always wins. Ramp slewing needs `PWM_RAMP_EN.
module pwm_ramp_ctrl #(
    parameter int          W          = 28,
    parameter int          STEP_W     = 16,
    parameter int unsigned DEF_PERIOD = 50000,
    parameter int unsigned DEF_DUTY   = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [W-1:0]      cfg_period,
    input  logic [W-1:0]      cfg_duty,
    input  logic [STEP_W-1:0] cfg_step,
    input  logic              cfg_load,
    input  logic              pwm_wrap,
    output logic [W-1:0]      act_period,
    output logic [W-1:0]      act_duty,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    typedef enum logic [1:0] {IDLE, ARM, RAMP, DONE} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] act_period_q, act_period_d;
    logic [W-1:0] act_duty_q, act_duty_d;
    logic [W-1:0] tgt_period_q, tgt_period_d;
    logic [W-1:0] tgt_duty_q, tgt_duty_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         cfg_err_q, cfg_err_d;
    logic [W-1:0] upd_duty;

`ifdef PWM_RAMP_EN
    logic [STEP_W-1:0] tgt_step_q, tgt_step_d;
    logic [W-1:0]      clamped, diff, step_ext, inc;
    logic              up;

    // Clamp to the new period first so a shrinking period never leaves duty above it.
    always_comb begin
        clamped  = (act_duty_q > tgt_period_q) ? tgt_period_q : act_duty_q;
        up       = (tgt_duty_q >= clamped);
        diff     = up ? (tgt_duty_q - clamped) : (clamped - tgt_duty_q);
        step_ext = {{(W-STEP_W){1'b0}}, tgt_step_q};
        inc      = ((tgt_step_q == '0) || (step_ext > diff)) ? diff : step_ext;
        upd_duty = up ? (clamped + inc) : (clamped - inc);
    end
`else
    logic unused_cfg_step;
    assign unused_cfg_step = ^cfg_step;
    assign upd_duty = tgt_duty_q;
`endif

    always_comb begin
        state_d      = state_q;
        act_period_d = act_period_q;
        act_duty_d   = act_duty_q;
        tgt_period_d = tgt_period_q;
        tgt_duty_d   = tgt_duty_q;
        cfg_err_d    = cfg_err_q;
`ifdef PWM_RAMP_EN
        tgt_step_d   = tgt_step_q;
`endif
        if (cfg_load && (cfg_period < W'(2))) begin
            cfg_err_d = 1'b1;
        end
        if (cfg_load && (cfg_period >= W'(2))) begin
            tgt_period_d = cfg_period;
            tgt_duty_d   = (cfg_duty > cfg_period) ? cfg_period : cfg_duty;
            cfg_err_d    = (cfg_duty > cfg_period);
`ifdef PWM_RAMP_EN
            tgt_step_d   = cfg_step;
`endif
            state_d      = ARM;
        end else begin
            case (state_q)
                ARM, RAMP: begin
                    if (pwm_wrap) begin
                        act_period_d = tgt_period_q;
                        act_duty_d   = upd_duty;
                        state_d      = (upd_duty == tgt_duty_q) ? DONE : RAMP;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == ARM) || (state_d == RAMP);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            act_period_q <= W'(DEF_PERIOD);
            act_duty_q   <= W'(DEF_DUTY);
            tgt_period_q <= W'(DEF_PERIOD);
            tgt_duty_q   <= W'(DEF_DUTY);
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
`ifdef PWM_RAMP_EN
            tgt_step_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            act_period_q <= act_period_d;
            act_duty_q   <= act_duty_d;
            tgt_period_q <= tgt_period_d;
            tgt_duty_q   <= tgt_duty_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_err_q    <= cfg_err_d;
`ifdef PWM_RAMP_EN
            tgt_step_q   <= tgt_step_d;
`endif
        end
    end

    assign act_period = act_period_q;
    assign act_duty   = act_duty_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;

endmodule
